csr_file: RTL and testbench
===========================

CSR_FILE -- requirements
Module: csr_file

Interface
REQ-001 SHALL have parameter XLEN, default 32, giving the data width of every CSR port.
REQ-002 SHALL have parameter HARTID, default 0, giving the value returned by mhartid.
REQ-003 i_clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 i_rstn  in  1  synchronous, active-low reset, sampled on the i_clk rising edge.
REQ-005 i_csr_raddr  in  12  read address from the decode/SCU path.
REQ-006 o_csr_rdata  out  XLEN  combinational read data (feeds the SCU i_csr_rdata input).
REQ-007 o_csr_rillegal  out  1  i_csr_raddr is unimplemented.
REQ-008 i_csr_wen  in  1  write strobe (SCU o_csr_wen).
REQ-009 i_csr_waddr  in  12  write address.
REQ-010 i_csr_wdata  in  XLEN  write data (SCU o_csr_wdata).
REQ-011 i_instret  in  1  one-cycle pulse per retired instruction.
REQ-012 i_trap  in  1  synchronous exception entry pulse.
REQ-013 i_trap_cause  in  XLEN  exception mcause value.
REQ-014 i_trap_pc  in  XLEN  PC saved to mepc on trap or interrupt entry.
REQ-015 i_trap_tval  in  XLEN  value saved to mtval on trap entry.
REQ-016 i_irq_take  in  1  pipeline accepts the pending interrupt this cycle.
REQ-017 i_mret  in  1  mret retire pulse.
REQ-018 i_ext_irq, i_tmr_irq, i_sw_irq  in  1 each  asynchronous interrupt lines.
REQ-019 o_irq_req  out  1  interrupt pending and enabled.
REQ-020 o_mtvec  out  XLEN  trap target.
REQ-021 o_mepc  out  XLEN  mret target.

Function
REQ-022 SHALL implement the following registers:
- mstatus (0x300): MIE bit 3, MPIE bit 7; MPP bits 12:11 read 2'b11; all other bits read 0.
- misa (0x301): read-only constant RV32I.
- mie (0x304): writable bits 3, 7 and 11 only.
- mtvec (0x305): bits 1:0 read 0.
- mscratch (0x340).
- mepc (0x341): bit 0 reads 0.
- mcause (0x342), mtval (0x343).
- mip (0x344): read-only, MEIP bit 11, MTIP bit 7, MSIP bit 3.
- mcycle/mcycleh (0xB00/0xB80), minstret/minstreth (0xB02/0xB82).
- mhartid (0xF14): read-only HARTID.
REQ-023 Reads SHALL be combinational with zero latency; writes take effect the cycle after i_csr_wen.
REQ-024 Unimplemented addresses SHALL read 0, assert o_csr_rillegal, and ignore writes; writes to read-only registers SHALL be ignored.
REQ-025 mip bits SHALL be each irq line registered through a 2-flop synchronizer, giving 2-cycle latency.
REQ-026 o_irq_req SHALL equal mstatus.MIE & |(mie & mip), with no registered delay.
REQ-027 On i_irq_take, mcause SHALL load the highest-priority pending cause: MEI 0x8000000B > MSI 0x80000003 > MTI 0x80000007; mtval SHALL load 0.
REQ-028 On i_trap or i_irq_take the block SHALL, in one cycle:
- load mepc from i_trap_pc;
- load MPIE from MIE;
- clear MIE.
REQ-029 On i_mret it SHALL load MIE from MPIE and set MPIE to 1.
REQ-030 Priority for simultaneous events SHALL be: i_trap > i_irq_take > i_mret > i_csr_wen, applied to every register the higher-priority event touches; other registers written the same cycle still update.
REQ-031 mcycle SHALL be a 64-bit counter incrementing every cycle, wrapping from 0xFFFFFFFF_FFFFFFFF to 0; minstret SHALL increment on i_instret with the same wrap.
REQ-032 A CSR write to any counter half SHALL override that cycle's increment for that half; the other half is left unchanged by the write.
REQ-033 o_mtvec SHALL be the mtvec register; o_mepc SHALL be the mepc register.

Reset
REQ-034 With i_rstn low at a clock edge, the following SHALL reset:
- mstatus.MIE = 0, mstatus.MPIE = 0;
- mie, mip synchronizers, mcause, mtval, mepc, mscratch and both counters = 0;
- mtvec = `reset_mtvec (defines.v).
REQ-035 During reset, o_irq_req SHALL be 0, and any simultaneous trap, mret or write SHALL be discarded.
REQ-036 Mid-operation reset SHALL take precedence over every event in the same cycle.

Structure
REQ-037 CSR addresses, mstatus/mie/mip bit positions, cause codes and the mtvec reset value SHALL live in the shared defines.v.
REQ-038 The two 64-bit counters SHALL each be an instance of one sub-module, csr_counter64, with inputs inc, wen_lo, wen_hi and wdata.

Verification
REQ-039 Write mtvec 0x8000_0103 -> read 0x8000_0100 next cycle; o_mtvec = 0x8000_0100.
REQ-040 Set MIE=1 and mie=0x800, pulse i_ext_irq -> o_irq_req rises 2 cycles later; i_irq_take with pc 0x1000 gives:
- mcause 0x8000000B;
- mepc 0x1000;
- MIE 0, MPIE 1.
REQ-041 After REQ-040, pulse i_mret -> MIE 1, MPIE 1.
REQ-042 Write mcycle = 0xFFFFFFFF, mcycleh = 0 -> after 2 cycles, mcycleh = 1 and mcycle = 1.
REQ-043 Same cycle: i_trap (cause 2, tval 0xDEAD) plus i_csr_wen to mcause 0x5 -> mcause 2, mtval 0xDEAD.
REQ-044 Read 0x7C0 -> rdata 0 and o_csr_rillegal 1; assert reset mid-count -> all counters 0 next cycle.

Source files
------------

// File: rtl/csr_file_pkg.sv
// Shared CSR addresses, bit positions, cause codes and reset constants
// for the machine-mode CSR file.
package csr_file_pkg;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MISA     = 12'h301;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MHARTID  = 12'hF14;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int IRQ_MSI = 3;
  localparam int IRQ_MTI = 7;
  localparam int IRQ_MEI = 11;

  localparam logic [31:0] CAUSE_MSI = 32'h8000_0003;
  localparam logic [31:0] CAUSE_MTI = 32'h8000_0007;
  localparam logic [31:0] CAUSE_MEI = 32'h8000_000B;

  localparam logic [31:0] RESET_MTVEC = 32'h0000_0100;
  localparam logic [31:0] MISA_RV32I  = 32'h4000_0100;

  typedef struct packed {
    logic mei;
    logic mti;
    logic msi;
  } irq_vec_t;

  // Interrupt priority: external, then software, then timer.
  function automatic logic [31:0] irq_cause(irq_vec_t pend);
    if (pend.mei)      return CAUSE_MEI;
    else if (pend.msi) return CAUSE_MSI;
    else if (pend.mti) return CAUSE_MTI;
    else               return CAUSE_MEI;
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// Double-width free-running counter split into two CSR-writable halves.
module csr_counter64 #(
  parameter int W = 32
) (
  input  logic           i_clk,
  input  logic           i_rstn,
  input  logic           inc,
  input  logic           wen_lo,
  input  logic           wen_hi,
  input  logic [W-1:0]   wdata,
  output logic [2*W-1:0] count
);

  logic [2*W-1:0] cnt_q, cnt_d;

  // A write to one half replaces only that half's incremented value.
  always_comb begin
    cnt_d = cnt_q + {{(2*W-1){1'b0}}, inc};
    if (wen_lo) cnt_d[W-1:0]   = wdata;
    if (wen_hi) cnt_d[2*W-1:W] = wdata;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign count = cnt_q;

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file: trap/interrupt entry, mret, interrupt request
// generation and the cycle/instret counters.
module csr_file
  import csr_file_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int HARTID = 0
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic [11:0]     i_csr_raddr,
  output logic [XLEN-1:0] o_csr_rdata,
  output logic            o_csr_rillegal,
  input  logic            i_csr_wen,
  input  logic [11:0]     i_csr_waddr,
  input  logic [XLEN-1:0] i_csr_wdata,
  input  logic            i_instret,
  input  logic            i_trap,
  input  logic [XLEN-1:0] i_trap_cause,
  input  logic [XLEN-1:0] i_trap_pc,
  input  logic [XLEN-1:0] i_trap_tval,
  input  logic            i_irq_take,
  input  logic            i_mret,
  input  logic            i_ext_irq,
  input  logic            i_tmr_irq,
  input  logic            i_sw_irq,
  output logic            o_irq_req,
  output logic [XLEN-1:0] o_mtvec,
  output logic [XLEN-1:0] o_mepc
);

  localparam logic [XLEN-1:0] MTVEC_RST  = XLEN'(RESET_MTVEC);
  localparam logic [XLEN-1:0] MTVEC_MASK = ~XLEN'(3);
  localparam logic [XLEN-1:0] MEPC_MASK  = ~XLEN'(1);

  logic            mie_q, mie_d, mpie_q, mpie_d;
  irq_vec_t        irq_en_q, irq_en_d;
  irq_vec_t        sync1_q, sync2_q, pending;
  logic [XLEN-1:0] mtvec_q, mtvec_d, mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d;
  logic [2*XLEN-1:0] mcycle_cnt, minstret_cnt;

  logic we_mcycle, we_mcycleh, we_minstret, we_minstreth;

  assign we_mcycle    = i_csr_wen && (i_csr_waddr == CSR_MCYCLE);
  assign we_mcycleh   = i_csr_wen && (i_csr_waddr == CSR_MCYCLEH);
  assign we_minstret  = i_csr_wen && (i_csr_waddr == CSR_MINSTRET);
  assign we_minstreth = i_csr_wen && (i_csr_waddr == CSR_MINSTRETH);

  assign pending   = irq_en_q & sync2_q;
  assign o_irq_req = i_rstn & mie_q & (|pending);
  assign o_mtvec   = mtvec_q & MTVEC_MASK;
  assign o_mepc    = mepc_q & MEPC_MASK;

  // Later assignments win: csr write < mret < irq entry < trap entry.
  always_comb begin
    mie_d      = mie_q;
    mpie_d     = mpie_q;
    irq_en_d   = irq_en_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    if (i_csr_wen) begin
      case (i_csr_waddr)
        CSR_MSTATUS: begin
          mie_d  = i_csr_wdata[MSTATUS_MIE];
          mpie_d = i_csr_wdata[MSTATUS_MPIE];
        end
        CSR_MIE: begin
          irq_en_d.mei = i_csr_wdata[IRQ_MEI];
          irq_en_d.mti = i_csr_wdata[IRQ_MTI];
          irq_en_d.msi = i_csr_wdata[IRQ_MSI];
        end
        CSR_MTVEC:    mtvec_d    = i_csr_wdata;
        CSR_MSCRATCH: mscratch_d = i_csr_wdata;
        CSR_MEPC:     mepc_d     = i_csr_wdata;
        CSR_MCAUSE:   mcause_d   = i_csr_wdata;
        CSR_MTVAL:    mtval_d    = i_csr_wdata;
        default: ;
      endcase
    end
    if (i_mret) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end
    if (i_trap || i_irq_take) begin
      mepc_d   = i_trap_pc;
      mpie_d   = mie_q;
      mie_d    = 1'b0;
      mcause_d = i_trap ? i_trap_cause : XLEN'(irq_cause(pending));
      mtval_d  = i_trap ? i_trap_tval : '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      irq_en_q   <= '0;
      mtvec_q    <= MTVEC_RST;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
    end else begin
      mie_q      <= mie_d;
      mpie_q     <= mpie_d;
      irq_en_q   <= irq_en_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
      sync1_q    <= '{mei: i_ext_irq, mti: i_tmr_irq, msi: i_sw_irq};
      sync2_q    <= sync1_q;
    end
  end

  csr_counter64 #(.W(XLEN)) u_mcycle (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .inc    (1'b1),
    .wen_lo (we_mcycle),
    .wen_hi (we_mcycleh),
    .wdata  (i_csr_wdata),
    .count  (mcycle_cnt)
  );

  csr_counter64 #(.W(XLEN)) u_minstret (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .inc    (i_instret),
    .wen_lo (we_minstret),
    .wen_hi (we_minstreth),
    .wdata  (i_csr_wdata),
    .count  (minstret_cnt)
  );

  always_comb begin
    o_csr_rdata    = '0;
    o_csr_rillegal = 1'b0;
    case (i_csr_raddr)
      CSR_MSTATUS: begin
        o_csr_rdata[MSTATUS_MIE]  = mie_q;
        o_csr_rdata[MSTATUS_MPIE] = mpie_q;
        o_csr_rdata[12:11]        = 2'b11;
      end
      CSR_MISA: o_csr_rdata = XLEN'(MISA_RV32I);
      CSR_MIE: begin
        o_csr_rdata[IRQ_MEI] = irq_en_q.mei;
        o_csr_rdata[IRQ_MTI] = irq_en_q.mti;
        o_csr_rdata[IRQ_MSI] = irq_en_q.msi;
      end
      CSR_MTVEC:    o_csr_rdata = mtvec_q & MTVEC_MASK;
      CSR_MSCRATCH: o_csr_rdata = mscratch_q;
      CSR_MEPC:     o_csr_rdata = mepc_q & MEPC_MASK;
      CSR_MCAUSE:   o_csr_rdata = mcause_q;
      CSR_MTVAL:    o_csr_rdata = mtval_q;
      CSR_MIP: begin
        o_csr_rdata[IRQ_MEI] = sync2_q.mei;
        o_csr_rdata[IRQ_MTI] = sync2_q.mti;
        o_csr_rdata[IRQ_MSI] = sync2_q.msi;
      end
      CSR_MCYCLE:    o_csr_rdata = mcycle_cnt[XLEN-1:0];
      CSR_MCYCLEH:   o_csr_rdata = mcycle_cnt[2*XLEN-1:XLEN];
      CSR_MINSTRET:  o_csr_rdata = minstret_cnt[XLEN-1:0];
      CSR_MINSTRETH: o_csr_rdata = minstret_cnt[2*XLEN-1:XLEN];
      CSR_MHARTID:   o_csr_rdata = XLEN'(HARTID);
      default:       o_csr_rillegal = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_csr_file.sv
// Self-checking bench for csr_file: directed scenarios plus randomized
// traffic compared against a behavioural CSR model.
module tb_csr_file;

  localparam int HART = 3;

  logic        clk = 1'b0;
  logic        rstn;
  logic [11:0] raddr, waddr;
  logic [31:0] rdata, wdata, cause, pc, tval, mtvec_o, mepc_o;
  logic        rillegal, wen, instret, trap, take, mret;
  logic        ext, tmr, sw, irq_req;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  csr_file #(.XLEN(32), .HARTID(HART)) dut (
    .i_clk          (clk),
    .i_rstn         (rstn),
    .i_csr_raddr    (raddr),
    .o_csr_rdata    (rdata),
    .o_csr_rillegal (rillegal),
    .i_csr_wen      (wen),
    .i_csr_waddr    (waddr),
    .i_csr_wdata    (wdata),
    .i_instret      (instret),
    .i_trap         (trap),
    .i_trap_cause   (cause),
    .i_trap_pc      (pc),
    .i_trap_tval    (tval),
    .i_irq_take     (take),
    .i_mret         (mret),
    .i_ext_irq      (ext),
    .i_tmr_irq      (tmr),
    .i_sw_irq       (sw),
    .o_irq_req      (irq_req),
    .o_mtvec        (mtvec_o),
    .o_mepc         (mepc_o)
  );

  // Behavioural model state
  bit        m_mie, m_mpie;
  bit [31:0] m_iemask, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
  bit [63:0] m_cyc, m_ins;
  bit [2:0]  m_s1, m_s2;   // {ext, tmr, sw}

  bit [11:0] addrs [17] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
                            12'h342, 12'h343, 12'h344, 12'hB00, 12'hB80, 12'hB02,
                            12'hB82, 12'hF14, 12'h7C0, 12'h000, 12'hB03};

  function automatic bit [31:0] mdl_mip();
    return (32'(m_s2[2]) << 11) | (32'(m_s2[1]) << 7) | (32'(m_s2[0]) << 3);
  endfunction

  function automatic bit mdl_irq_req();
    return rstn && m_mie && ((m_iemask & mdl_mip()) != 0);
  endfunction

  function automatic bit [31:0] mdl_read(input bit [11:0] a, output bit ill);
    ill = 1'b0;
    case (a)
      12'h300: return 32'h1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
      12'h301: return 32'h4000_0100;
      12'h304: return m_iemask;
      12'h305: return m_mtvec & 32'hFFFF_FFFC;
      12'h340: return m_mscratch;
      12'h341: return m_mepc & 32'hFFFF_FFFE;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      12'h344: return mdl_mip();
      12'hB00: return m_cyc[31:0];
      12'hB80: return m_cyc[63:32];
      12'hB02: return m_ins[31:0];
      12'hB82: return m_ins[63:32];
      12'hF14: return HART;
      default: begin ill = 1'b1; return 32'h0; end
    endcase
  endfunction

  // Apply one clock edge of the architectural rules to the model.
  function automatic void mdl_step();
    bit n_mie, n_mpie;
    bit [31:0] n_ie, n_tv, n_sc, n_epc, n_ca, n_tval, pend;
    bit [63:0] n_cyc, n_ins;
    if (!rstn) begin
      m_mie = 0; m_mpie = 0; m_iemask = 0; m_mtvec = 32'h100; m_mscratch = 0;
      m_mepc = 0; m_mcause = 0; m_mtval = 0; m_cyc = 0; m_ins = 0; m_s1 = 0; m_s2 = 0;
      return;
    end
    pend = m_iemask & mdl_mip();
    n_mie = m_mie; n_mpie = m_mpie; n_ie = m_iemask; n_tv = m_mtvec; n_sc = m_mscratch;
    n_epc = m_mepc; n_ca = m_mcause; n_tval = m_mtval;
    n_cyc = m_cyc + 64'd1;
    n_ins = m_ins + 64'(instret);
    if (wen) begin
      case (waddr)
        12'h300: begin n_mie = wdata[3]; n_mpie = wdata[7]; end
        12'h304: n_ie = wdata & 32'h888;
        12'h305: n_tv = wdata;
        12'h340: n_sc = wdata;
        12'h341: n_epc = wdata;
        12'h342: n_ca = wdata;
        12'h343: n_tval = wdata;
        12'hB00: n_cyc = {n_cyc[63:32], wdata};
        12'hB80: n_cyc = {wdata, n_cyc[31:0]};
        12'hB02: n_ins = {n_ins[63:32], wdata};
        12'hB82: n_ins = {wdata, n_ins[31:0]};
        default: ;
      endcase
    end
    if (mret) begin n_mie = m_mpie; n_mpie = 1; end
    if (trap || take) begin
      n_epc = pc; n_mpie = m_mie; n_mie = 0;
      if (trap) begin n_ca = cause; n_tval = tval; end
      else begin
        n_tval = 0;
        n_ca = pend[11] ? 32'h8000_000B : pend[3] ? 32'h8000_0003 : 32'h8000_0007;
      end
    end
    m_mie = n_mie; m_mpie = n_mpie; m_iemask = n_ie; m_mtvec = n_tv; m_mscratch = n_sc;
    m_mepc = n_epc; m_mcause = n_ca; m_mtval = n_tval; m_cyc = n_cyc; m_ins = n_ins;
    m_s2 = m_s1;
    m_s1 = {ext, tmr, sw};
  endfunction

  task automatic tick();
    @(posedge clk);
    mdl_step();
    #1;
  endtask

  task automatic idle_inputs();
    wen = 0; waddr = 0; wdata = 0; instret = 0; trap = 0; take = 0; mret = 0;
    ext = 0; tmr = 0; sw = 0; cause = 0; pc = 0; tval = 0;
  endtask

  task automatic csr_wr(input bit [11:0] a, input bit [31:0] d);
    wen = 1; waddr = a; wdata = d;
    tick();
    wen = 0;
  endtask

  task automatic test_reset();
    rstn = 0;
    idle_inputs();
    raddr = 12'h300;
    tick(); tick();
    vectors++;
    if (rdata !== 32'h1800) begin
      miscompares++; $display("FAIL reset_mstatus got %h want %h", rdata, 32'h1800);
    end
    vectors++;
    if (mtvec_o !== 32'h100) begin
      miscompares++; $display("FAIL reset_mtvec got %h want %h", mtvec_o, 32'h100);
    end
    vectors++;
    if (irq_req !== 1'b0 || mepc_o !== 32'h0) begin
      miscompares++; $display("FAIL reset_irq_mepc got %b/%h want 0/0", irq_req, mepc_o);
    end
    raddr = 12'hB00; #1;
    vectors++;
    if (rdata !== 32'h0) begin
      miscompares++; $display("FAIL reset_mcycle got %h want 0", rdata);
    end
    rstn = 1;
    tick();
  endtask

  task automatic test_mtvec();
    csr_wr(12'h305, 32'h8000_0103);
    raddr = 12'h305; #1;
    vectors++;
    if (rdata !== 32'h8000_0100 || mtvec_o !== 32'h8000_0100) begin
      miscompares++;
      $display("FAIL mtvec_write got rd=%h out=%h want 80000100", rdata, mtvec_o);
    end
  endtask

  task automatic test_irq_entry();
    csr_wr(12'h300, 32'h8);
    csr_wr(12'h304, 32'h800);
    ext = 1;
    tick();
    ext = 0;
    vectors++;
    if (irq_req !== 1'b0) begin
      miscompares++; $display("FAIL irq_latency1 got %b want 0", irq_req);
    end
    tick();
    vectors++;
    if (irq_req !== 1'b1) begin
      miscompares++; $display("FAIL irq_latency2 got %b want 1", irq_req);
    end
    take = 1; pc = 32'h1000;
    tick();
    take = 0;
    raddr = 12'h342; #1;
    vectors++;
    if (rdata !== 32'h8000_000B) begin
      miscompares++; $display("FAIL irq_mcause got %h want 8000000b", rdata);
    end
    raddr = 12'h341; #1;
    vectors++;
    if (rdata !== 32'h1000 || mepc_o !== 32'h1000) begin
      miscompares++; $display("FAIL irq_mepc got %h/%h want 1000", rdata, mepc_o);
    end
    raddr = 12'h300; #1;
    vectors++;
    if (rdata !== 32'h1880) begin
      miscompares++; $display("FAIL irq_mstatus got %h want 1880", rdata);
    end
    raddr = 12'h343; #1;
    vectors++;
    if (rdata !== 32'h0) begin
      miscompares++; $display("FAIL irq_mtval got %h want 0", rdata);
    end
  endtask

  task automatic test_mret();
    mret = 1;
    tick();
    mret = 0;
    raddr = 12'h300; #1;
    vectors++;
    if (rdata !== 32'h1888) begin
      miscompares++; $display("FAIL mret_mstatus got %h want 1888", rdata);
    end
  endtask

  task automatic test_counter_wrap();
    csr_wr(12'hB80, 32'h0);
    csr_wr(12'hB00, 32'hFFFF_FFFF);
    tick(); tick();
    raddr = 12'hB80; #1;
    vectors++;
    if (rdata !== 32'h1) begin
      miscompares++; $display("FAIL wrap_mcycleh got %h want 1", rdata);
    end
    raddr = 12'hB00; #1;
    vectors++;
    if (rdata !== 32'h1) begin
      miscompares++; $display("FAIL wrap_mcycle got %h want 1", rdata);
    end
  endtask

  task automatic test_trap_priority();
    trap = 1; cause = 32'h2; tval = 32'hDEAD; pc = 32'h2004;
    wen = 1; waddr = 12'h342; wdata = 32'h5;
    tick();
    idle_inputs();
    raddr = 12'h342; #1;
    vectors++;
    if (rdata !== 32'h2) begin
      miscompares++; $display("FAIL trap_mcause got %h want 2", rdata);
    end
    raddr = 12'h343; #1;
    vectors++;
    if (rdata !== 32'hDEAD) begin
      miscompares++; $display("FAIL trap_mtval got %h want dead", rdata);
    end
    vectors++;
    if (mepc_o !== 32'h2004) begin
      miscompares++; $display("FAIL trap_mepc got %h want 2004", mepc_o);
    end
  endtask

  task automatic test_illegal_midreset();
    raddr = 12'h7C0; #1;
    vectors++;
    if (rdata !== 32'h0 || rillegal !== 1'b1) begin
      miscompares++; $display("FAIL illegal_read got %h/%b want 0/1", rdata, rillegal);
    end
    raddr = 12'h301; #1;
    vectors++;
    if (rillegal !== 1'b0 || rdata !== 32'h4000_0100) begin
      miscompares++; $display("FAIL misa_read got %h/%b want 40000100/0", rdata, rillegal);
    end
    instret = 1;
    repeat (5) tick();
    rstn = 0; wen = 1; waddr = 12'hB00; wdata = 32'h55; trap = 1; pc = 32'h44;
    tick();
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      raddr = (i == 0) ? 12'hB00 : (i == 1) ? 12'hB80 : (i == 2) ? 12'hB02 : 12'hB82;
      #1;
      vectors++;
      if (rdata !== 32'h0) begin
        miscompares++; $display("FAIL midreset_counter %h got %h want 0", raddr, rdata);
      end
    end
    vectors++;
    if (mepc_o !== 32'h0 || irq_req !== 1'b0) begin
      miscompares++; $display("FAIL midreset_state got %h/%b want 0/0", mepc_o, irq_req);
    end
    rstn = 1;
    tick();
  endtask

  task automatic test_random();
    bit        ill;
    bit [31:0] exp;
    rstn = 0; idle_inputs();
    tick(); tick();
    rstn = 1;
    for (int n = 0; n < 3000; n++) begin
      rstn    = ($urandom_range(99) != 0);
      wen     = ($urandom_range(2) == 0);
      waddr   = addrs[$urandom_range(16)];
      wdata   = $urandom;
      instret = 1'($urandom_range(1));
      trap    = ($urandom_range(19) == 0);
      take    = mdl_irq_req() && ($urandom_range(2) == 0);
      mret    = ($urandom_range(14) == 0);
      ext     = ($urandom_range(3) == 0);
      tmr     = ($urandom_range(3) == 0);
      sw      = ($urandom_range(3) == 0);
      cause   = $urandom; pc = $urandom; tval = $urandom;
      tick();
      raddr = addrs[$urandom_range(16)];
      #1;
      exp = mdl_read(raddr, ill);
      vectors++;
      if (rdata !== exp || rillegal !== ill) begin
        miscompares++;
        $display("FAIL rand_read addr %h got %h/%b want %h/%b", raddr, rdata, rillegal, exp, ill);
      end
      vectors++;
      if (irq_req !== mdl_irq_req()) begin
        miscompares++; $display("FAIL rand_irq_req got %b want %b", irq_req, mdl_irq_req());
      end
      vectors++;
      if (mtvec_o !== (m_mtvec & 32'hFFFF_FFFC) || mepc_o !== (m_mepc & 32'hFFFF_FFFE)) begin
        miscompares++;
        $display("FAIL rand_outs got %h/%h want %h/%h", mtvec_o, mepc_o,
                 m_mtvec & 32'hFFFF_FFFC, m_mepc & 32'hFFFF_FFFE);
      end
    end
    idle_inputs();
    rstn = 1;
  endtask

  initial begin
    rstn = 0;
    raddr = 0;
    idle_inputs();
    test_reset();
    test_mtvec();
    test_irq_entry();
    test_mret();
    test_counter_wrap();
    test_trap_priority();
    test_illegal_midreset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
